// File: rtl/sprite_ctrl_pkg.sv
// Shared register map, bit positions and reset-position helpers for sprite_ctrl.
package sprite_ctrl_pkg;

  localparam logic [2:0] REG_STAGE_X   = 3'd0;
  localparam logic [2:0] REG_STAGE_Y   = 3'd1;
  localparam logic [2:0] REG_VEL_X     = 3'd2;
  localparam logic [2:0] REG_VEL_Y     = 3'd3;
  localparam logic [2:0] REG_CTRL      = 3'd4;
  localparam logic [2:0] REG_STATUS    = 3'd5;
  localparam logic [2:0] REG_FRAME_CNT = 3'd6;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_MOTION = 1;
  localparam int unsigned CTRL_BOUNCE = 2;
  localparam int unsigned CTRL_LOAD   = 3;

  localparam int unsigned ST_LEFT   = 0;
  localparam int unsigned ST_RIGHT  = 1;
  localparam int unsigned ST_TOP    = 2;
  localparam int unsigned ST_BOTTOM = 3;

  localparam int H_RES_DEF     = 640;
  localparam int V_RES_DEF     = 480;
  localparam int SPR_DRAWW_DEF = 64;
  localparam int SPR_DRAWH_DEF = 64;

  // Top-left coordinate that centres a sprite of the given draw size.
  function automatic int spr_centre(input int res, input int draw);
    return res / 2 - draw / 2;
  endfunction

  localparam int SPRX_RST_DEF = spr_centre(H_RES_DEF, SPR_DRAWW_DEF);
  localparam int SPRY_RST_DEF = spr_centre(V_RES_DEF, SPR_DRAWH_DEF);

endpackage

// File: rtl/sprite_ctrl_axis_step.sv
// One-axis position step with bounce/wrap at inclusive bounds; purely combinational.
module axis_step
  import sprite_ctrl_pkg::*;
#(
  parameter int CORDW = 16
) (
  input  logic signed [CORDW-1:0] i_pos,
  input  logic signed [CORDW-1:0] i_vel,
  input  logic signed [CORDW-1:0] i_lo,
  input  logic signed [CORDW-1:0] i_hi,
  input  logic                    i_bounce,
  output logic signed [CORDW-1:0] o_pos,
  output logic signed [CORDW-1:0] o_vel,
  output logic                    o_hit_lo,
  output logic                    o_hit_hi
);

  logic signed [CORDW:0] w_next;
  logic signed [CORDW:0] w_lo_ext;
  logic signed [CORDW:0] w_hi_ext;

  // One guard bit so the sum cannot overflow before the bound compare.
  assign w_next   = {i_pos[CORDW-1], i_pos} + {i_vel[CORDW-1], i_vel};
  assign w_lo_ext = {i_lo[CORDW-1], i_lo};
  assign w_hi_ext = {i_hi[CORDW-1], i_hi};

  always_comb begin
    o_pos    = w_next[CORDW-1:0];
    o_vel    = i_vel;
    o_hit_lo = 1'b0;
    o_hit_hi = 1'b0;
    if (w_next > w_hi_ext) begin
      o_hit_hi = 1'b1;
      o_pos    = i_bounce ? i_hi : i_lo;
      if (i_bounce) o_vel = -i_vel;
    end else if (w_next < w_lo_ext) begin
      o_hit_lo = 1'b1;
      o_pos    = i_bounce ? i_lo : i_hi;
      if (i_bounce) o_vel = -i_vel;
    end
  end

endmodule

// File: rtl/sprite_ctrl.sv
// CPU register bank that commits or advances the sprite position once per frame.
module sprite_ctrl
  import sprite_ctrl_pkg::*;
#(
  parameter int CORDW     = 16,
  parameter int H_RES     = H_RES_DEF,
  parameter int V_RES     = V_RES_DEF,
  parameter int SPR_DRAWW = SPR_DRAWW_DEF,
  parameter int SPR_DRAWH = SPR_DRAWH_DEF,
  parameter int MARGIN    = 128
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_frame,
  input  logic                    i_wr_en,
  input  logic [2:0]              i_wr_addr,
  input  logic [CORDW-1:0]        i_wr_data,
  input  logic [2:0]              i_rd_addr,
  output logic [CORDW-1:0]        o_rd_data,
  output logic signed [CORDW-1:0] o_sprx,
  output logic signed [CORDW-1:0] o_spry,
  output logic                    o_spr_en
);

  localparam logic signed [CORDW-1:0] X_LO  = CORDW'(-MARGIN);
  localparam logic signed [CORDW-1:0] X_HI  = CORDW'(H_RES + MARGIN - SPR_DRAWW);
  localparam logic signed [CORDW-1:0] Y_LO  = CORDW'(-MARGIN);
  localparam logic signed [CORDW-1:0] Y_HI  = CORDW'(V_RES + MARGIN - SPR_DRAWH);
  localparam logic signed [CORDW-1:0] X_RST = CORDW'(spr_centre(H_RES, SPR_DRAWW));
  localparam logic signed [CORDW-1:0] Y_RST = CORDW'(spr_centre(V_RES, SPR_DRAWH));

  logic signed [CORDW-1:0] r_stage_x, r_stage_y, r_vel_x, r_vel_y, r_sprx, r_spry;
  logic [3:0]              r_ctrl, r_status;
  logic [15:0]             r_frame_cnt;
  logic [CORDW-1:0]        r_rd_data;
  logic                    r_spr_en;

  logic signed [CORDW-1:0] w_stage_x_nxt, w_stage_y_nxt, w_vel_x_nxt, w_vel_y_nxt;
  logic signed [CORDW-1:0] w_sprx_nxt, w_spry_nxt;
  logic [3:0]              w_ctrl_nxt, w_status_nxt;
  logic [15:0]             w_frame_cnt_nxt;
  logic [CORDW-1:0]        w_rd_nxt;
  logic                    w_spr_en_nxt;

  logic signed [CORDW-1:0] w_x_pos, w_x_vel, w_y_pos, w_y_vel;
  logic                    w_x_hit_lo, w_x_hit_hi, w_y_hit_lo, w_y_hit_hi;

  axis_step #(.CORDW(CORDW)) u_step_x (
    .i_pos    (r_sprx),
    .i_vel    (r_vel_x),
    .i_lo     (X_LO),
    .i_hi     (X_HI),
    .i_bounce (r_ctrl[CTRL_BOUNCE]),
    .o_pos    (w_x_pos),
    .o_vel    (w_x_vel),
    .o_hit_lo (w_x_hit_lo),
    .o_hit_hi (w_x_hit_hi)
  );

  axis_step #(.CORDW(CORDW)) u_step_y (
    .i_pos    (r_spry),
    .i_vel    (r_vel_y),
    .i_lo     (Y_LO),
    .i_hi     (Y_HI),
    .i_bounce (r_ctrl[CTRL_BOUNCE]),
    .o_pos    (w_y_pos),
    .o_vel    (w_y_vel),
    .o_hit_lo (w_y_hit_lo),
    .o_hit_hi (w_y_hit_hi)
  );

  always_comb begin
    w_stage_x_nxt   = r_stage_x;
    w_stage_y_nxt   = r_stage_y;
    w_vel_x_nxt     = r_vel_x;
    w_vel_y_nxt     = r_vel_y;
    w_sprx_nxt      = r_sprx;
    w_spry_nxt      = r_spry;
    w_ctrl_nxt      = r_ctrl;
    w_frame_cnt_nxt = r_frame_cnt;
    w_spr_en_nxt    = r_spr_en;

    case (i_rd_addr)
      REG_STAGE_X:   w_rd_nxt = r_stage_x;
      REG_STAGE_Y:   w_rd_nxt = r_stage_y;
      REG_VEL_X:     w_rd_nxt = r_vel_x;
      REG_VEL_Y:     w_rd_nxt = r_vel_y;
      REG_CTRL:      w_rd_nxt = CORDW'(r_ctrl);
      REG_STATUS:    w_rd_nxt = CORDW'(r_status);
      REG_FRAME_CNT: w_rd_nxt = CORDW'(r_frame_cnt);
      default:       w_rd_nxt = '0;
    endcase

    // Clear-on-read drops the old bits; hits raised this cycle are OR-ed in after.
    w_status_nxt = (i_rd_addr == REG_STATUS) ? 4'h0 : r_status;

    if (i_frame) begin
      w_frame_cnt_nxt = r_frame_cnt + 16'd1;
      w_spr_en_nxt    = r_ctrl[CTRL_EN];
      if (r_ctrl[CTRL_LOAD]) begin
        w_sprx_nxt            = r_stage_x;
        w_spry_nxt            = r_stage_y;
        w_ctrl_nxt[CTRL_LOAD] = 1'b0;
      end else if (r_ctrl[CTRL_MOTION]) begin
        w_sprx_nxt              = w_x_pos;
        w_spry_nxt              = w_y_pos;
        w_vel_x_nxt             = w_x_vel;
        w_vel_y_nxt             = w_y_vel;
        w_status_nxt[ST_LEFT]   = w_status_nxt[ST_LEFT]   | w_x_hit_lo;
        w_status_nxt[ST_RIGHT]  = w_status_nxt[ST_RIGHT]  | w_x_hit_hi;
        w_status_nxt[ST_TOP]    = w_status_nxt[ST_TOP]    | w_y_hit_lo;
        w_status_nxt[ST_BOTTOM] = w_status_nxt[ST_BOTTOM] | w_y_hit_hi;
      end
    end

    // CPU writes land after the frame update so they win on a collision.
    if (i_wr_en) begin
      case (i_wr_addr)
        REG_STAGE_X: w_stage_x_nxt = i_wr_data;
        REG_STAGE_Y: w_stage_y_nxt = i_wr_data;
        REG_VEL_X:   w_vel_x_nxt   = i_wr_data;
        REG_VEL_Y:   w_vel_y_nxt   = i_wr_data;
        REG_CTRL: begin
          w_ctrl_nxt[CTRL_EN]     = i_wr_data[CTRL_EN];
          w_ctrl_nxt[CTRL_MOTION] = i_wr_data[CTRL_MOTION];
          w_ctrl_nxt[CTRL_BOUNCE] = i_wr_data[CTRL_BOUNCE];
          w_ctrl_nxt[CTRL_LOAD]   = w_ctrl_nxt[CTRL_LOAD] | i_wr_data[CTRL_LOAD];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stage_x   <= X_RST;
      r_stage_y   <= Y_RST;
      r_vel_x     <= CORDW'(4);
      r_vel_y     <= '0;
      r_sprx      <= X_RST;
      r_spry      <= Y_RST;
      r_ctrl      <= 4'h7;
      r_status    <= 4'h0;
      r_frame_cnt <= 16'd0;
      r_rd_data   <= '0;
      r_spr_en    <= 1'b1;
    end else begin
      r_stage_x   <= w_stage_x_nxt;
      r_stage_y   <= w_stage_y_nxt;
      r_vel_x     <= w_vel_x_nxt;
      r_vel_y     <= w_vel_y_nxt;
      r_sprx      <= w_sprx_nxt;
      r_spry      <= w_spry_nxt;
      r_ctrl      <= w_ctrl_nxt;
      r_status    <= w_status_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_rd_data   <= w_rd_nxt;
      r_spr_en    <= w_spr_en_nxt;
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_sprx    = r_sprx;
  assign o_spry    = r_spry;
  assign o_spr_en  = r_spr_en;

endmodule

// File: tb/tb_sprite_ctrl.sv
// Directed and randomized checks of sprite_ctrl against an integer reference model.
module tb_sprite_ctrl;

  localparam int X_LO = -128;
  localparam int X_HI = 704;
  localparam int Y_LO = -128;
  localparam int Y_HI = 544;

  logic               i_clk = 1'b0;
  logic               i_rst, i_frame, i_wr_en;
  logic [2:0]         i_wr_addr, i_rd_addr;
  logic [15:0]        i_wr_data;
  logic [15:0]        o_rd_data;
  logic signed [15:0] o_sprx, o_spry;
  logic               o_spr_en;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state, plain integers.
  int m_px, m_py, m_sx, m_sy, m_vx, m_vy;
  int m_en, m_mot, m_bnc, m_pend, m_status, m_cnt, m_rd, m_spr_en;

  sprite_ctrl u_dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_frame   (i_frame),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data),
    .o_sprx    (o_sprx),
    .o_spry    (o_spry),
    .o_spr_en  (o_spr_en)
  );

  always #20 i_clk = ~i_clk;

  function automatic int s16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input int exp);
    logic [15:0] e;
    e = exp[15:0];
    n_assert++;
    assert (got === e) else begin
      n_fail++;
      $error("FAIL %s: got 0x%04h expected 0x%04h", tag, got, e);
    end
  endtask

  task automatic model_reset();
    m_px = 288; m_py = 208; m_sx = 288; m_sy = 208; m_vx = 4; m_vy = 0;
    m_en = 1; m_mot = 1; m_bnc = 1; m_pend = 0;
    m_status = 0; m_cnt = 0; m_rd = 0; m_spr_en = 1;
  endtask

  task automatic axis(input int p, input int v, input int lo, input int hi, input int bnc,
                      output int np, output int nv, output int hl, output int hh);
    int n;
    n = p + v; np = n; nv = v; hl = 0; hh = 0;
    if (n > hi) begin
      hh = 1;
      np = bnc ? hi : lo;
      if (bnc != 0) nv = s16(-v);
    end else if (n < lo) begin
      hl = 1;
      np = bnc ? lo : hi;
      if (bnc != 0) nv = s16(-v);
    end
  endtask

  task automatic model_step();
    int npx, npy, nvx, nvy, a, b, c, d, nst;
    if (i_rst) begin
      model_reset();
      return;
    end
    case (i_rd_addr)
      3'd0:    m_rd = m_sx;
      3'd1:    m_rd = m_sy;
      3'd2:    m_rd = m_vx;
      3'd3:    m_rd = m_vy;
      3'd4:    m_rd = m_pend * 8 + m_bnc * 4 + m_mot * 2 + m_en;
      3'd5:    m_rd = m_status;
      3'd6:    m_rd = m_cnt;
      default: m_rd = 0;
    endcase
    nst = (i_rd_addr == 3'd5) ? 0 : m_status;
    if (i_frame) begin
      m_cnt = (m_cnt + 1) % 65536;
      m_spr_en = m_en;
      if (m_pend != 0) begin
        m_px = m_sx; m_py = m_sy; m_pend = 0;
      end else if (m_mot != 0) begin
        axis(m_px, m_vx, X_LO, X_HI, m_bnc, npx, nvx, a, b);
        axis(m_py, m_vy, Y_LO, Y_HI, m_bnc, npy, nvy, c, d);
        m_px = npx; m_py = npy; m_vx = nvx; m_vy = nvy;
        nst = nst | a | (b << 1) | (c << 2) | (d << 3);
      end
    end
    m_status = nst;
    if (i_wr_en) begin
      case (i_wr_addr)
        3'd0: m_sx = s16(int'(i_wr_data));
        3'd1: m_sy = s16(int'(i_wr_data));
        3'd2: m_vx = s16(int'(i_wr_data));
        3'd3: m_vy = s16(int'(i_wr_data));
        3'd4: begin
          m_en   = int'(i_wr_data[0]);
          m_mot  = int'(i_wr_data[1]);
          m_bnc  = int'(i_wr_data[2]);
          m_pend = m_pend | int'(i_wr_data[3]);
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
    tick();
    i_wr_en = 1'b0;
  endtask

  task automatic pulse_frame();
    i_frame = 1'b1;
    tick();
    i_frame = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [2:0] a, input int exp, input string tag);
    i_rd_addr = a;
    tick();
    chk(tag, o_rd_data, exp);
    i_rd_addr = 3'd7;
  endtask

  initial begin
    i_rst = 1'b1; i_frame = 1'b0; i_wr_en = 1'b0;
    i_wr_addr = 3'd0; i_wr_data = 16'h0; i_rd_addr = 3'd7;
    model_reset();
    tick(); tick();
    i_rst = 1'b0;

    // Reset state
    chk("rst_sprx", o_sprx, 288);
    chk("rst_spry", o_spry, 208);
    chk("rst_spr_en", o_spr_en, 1);
    rd(3'd4, 'h0007, "rst_ctrl");
    rd(3'd6, 0, "rst_frame_cnt");

    // Default motion
    repeat (10) pulse_frame();
    chk("motion_sprx", o_sprx, 328);
    chk("motion_spry", o_spry, 208);
    rd(3'd6, 10, "motion_frame_cnt");

    // Bounce off the right bound
    wr(3'd0, 16'd700);
    wr(3'd4, 16'h000F);
    pulse_frame();
    chk("bounce_load", o_sprx, 700);
    pulse_frame();
    chk("bounce_exact", o_sprx, 704);
    rd(3'd5, 0, "bounce_exact_status");
    pulse_frame();
    chk("bounce_clamp", o_sprx, 704);
    rd(3'd2, 'hFFFC, "bounce_vel");
    rd(3'd5, 'h0002, "bounce_status");
    rd(3'd5, 'h0000, "bounce_status_clr");

    // Wrap past the left bound
    wr(3'd4, 16'h000B);
    wr(3'd0, 16'hFF84);
    wr(3'd2, 16'hFFF8);
    pulse_frame();
    chk("wrap_load", o_sprx, -124);
    pulse_frame();
    chk("wrap_sprx", o_sprx, 704);
    rd(3'd5, 'h0001, "wrap_status");

    // CPU velocity write collides with a bouncing frame
    wr(3'd4, 16'h000F);
    wr(3'd0, 16'd702);
    wr(3'd2, 16'd4);
    pulse_frame();
    chk("coll_load", o_sprx, 702);
    i_frame = 1'b1; i_wr_en = 1'b1; i_wr_addr = 3'd2; i_wr_data = 16'd2;
    tick();
    i_frame = 1'b0; i_wr_en = 1'b0;
    chk("coll_sprx", o_sprx, 704);
    rd(3'd2, 2, "coll_vel_wins");
    rd(3'd5, 'h0002, "coll_status_pre");
    // Status read on the same cycle a hit is raised
    i_frame = 1'b1; i_rd_addr = 3'd5;
    tick();
    i_frame = 1'b0;
    chk("coll_status_old", o_rd_data, 0);
    tick();
    chk("coll_status_kept", o_rd_data, 'h0002);
    i_rd_addr = 3'd7;
    tick();

    // Reset with a load pending
    wr(3'd0, 16'd100);
    wr(3'd4, 16'h000F);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    pulse_frame();
    chk("rstload_sprx", o_sprx, 292);
    rd(3'd4, 'h0007, "rstload_ctrl");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      i_rst     = ($urandom_range(0, 249) == 0);
      i_frame   = ($urandom_range(0, 3) == 0);
      i_wr_en   = ($urandom_range(0, 2) == 0);
      i_wr_addr = 3'($urandom_range(0, 7));
      i_rd_addr = 3'($urandom_range(0, 7));
      case (i_wr_addr)
        3'd0, 3'd1: i_wr_data = 16'(int'($urandom_range(0, 1000)) - 200);
        3'd2, 3'd3: i_wr_data = 16'(int'($urandom_range(0, 60)) - 30);
        3'd4:       i_wr_data = 16'($urandom_range(0, 15));
        default:    i_wr_data = 16'($urandom);
      endcase
      tick();
      chk("rnd_sprx", o_sprx, m_px);
      chk("rnd_spry", o_spry, m_py);
      chk("rnd_spr_en", o_spr_en, m_spr_en);
      chk("rnd_rd_data", o_rd_data, m_rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_ctrl.md
# sprite_ctrl

CPU-facing sprite position controller for the VGA path. It holds a small memory-mapped register bank: staged position, velocity, control, status and a frame counter. Once per frame it commits or advances the sprite position, with bounce or wrap at the configured bounds. It sits directly upstream of the sprite renderer and drives its `sprx`/`spry` inputs, consuming the `frame` pulse from the sync generator.

## Interface
- `CORDW`, 16, signed coordinate width; also the register data width.
- `H_RES`, 640, active width.
- `V_RES`, 480, active height.
- `SPR_DRAWW`, 64, scaled sprite draw width.
- `SPR_DRAWH`, 64, scaled sprite draw height.
- `MARGIN`, 128, off-screen travel allowed beyond each edge.

- `clk` in 1: pixel clock (25 MHz domain). One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `frame` in 1: one-cycle pulse at start of frame.
- `wr_en` in 1: register write strobe.
- `wr_addr` in 3: write register index.
- `wr_data` in CORDW: write data.
- `rd_addr` in 3: read register index.
- `rd_data` out CORDW: read data, registered.
- `sprx` out CORDW: signed sprite x, registered.
- `spry` out CORDW: signed sprite y, registered.
- `spr_en` out 1: sprite visible, registered.

## Operation
- Register map:
  - 0 `STAGE_X` and 1 `STAGE_Y`: signed, R/W.
  - 2 `VEL_X` and 3 `VEL_Y`: signed pixels/frame, R/W.
  - 4 `CTRL` bits:
    - [0] enable.
    - [1] motion.
    - [2] bounce (0 = wrap).
    - [3] load request; writing 1 sets it, it self-clears on commit.
  - 5 `STATUS`: sticky hit bits [0] left, [1] right, [2] top, [3] bottom. Read-only; cleared by a read.
  - 6 `FRAME_CNT`: read-only, 16-bit, wraps.
  - 7 reads 0.
  - Writes to 5, 6 and 7 are ignored.
- Bounds:
  - x: lo = -MARGIN, hi = H_RES+MARGIN-SPR_DRAWW (defaults -128 / 704).
  - y: lo = -MARGIN, hi = V_RES+MARGIN-SPR_DRAWH (defaults -128 / 544).
- On a `frame` cycle:
  - `FRAME_CNT` += 1.
  - `spr_en` <= `CTRL[0]`. Enable is double-buffered, so there is no mid-frame change.
  - If load is pending: `sprx`/`spry` <= stage values, pending cleared, no motion this frame.
  - Else if motion is set: per axis, next = pos+vel computed at CORDW+1 bits.
    - next within [lo, hi] inclusive: pos <= next.
    - Bounce, next > hi: pos <= hi, vel <= -vel, set the hit bit.
    - Bounce, next < lo: pos <= lo, vel <= -vel, set the hit bit.
    - Wrap, next > hi: pos <= lo, set the hit bit.
    - Wrap, next < lo: pos <= hi, set the hit bit.
    - Landing exactly on a bound is not a hit.
  - Else: position holds.
- Simultaneous events:
  - CPU write to `VEL_*` or `CTRL` in the same cycle as a frame update: the CPU write wins, and the frame update uses the pre-write value.
  - `STATUS` read and a hit set in the same cycle: the read returns the old value, and the set bit remains 1.
  - Load request written in the same cycle as `frame`: it takes effect on the next frame.
- Reset values:
  - `sprx` = H_RES/2-SPR_DRAWW/2 (288), `spry` = V_RES/2-SPR_DRAWH/2 (208).
  - Stage registers equal the reset positions.
  - `VEL_X` = 4, `VEL_Y` = 0.
  - `CTRL` = 0x0007; no load pending.
  - `STATUS` = 0, `FRAME_CNT` = 0, `rd_data` = 0, `spr_en` = 1.
- Reset mid-operation discards any pending load and any sticky status.

## Timing
- Write: the register updates at the clock edge with `wr_en`, and is visible to a read issued the next cycle.
- Read: `rd_data` is valid one cycle after `rd_addr`. The `STATUS` clear occurs at the same edge that captures the data.
- `sprx`, `spry` and `spr_en` change only at the edge that samples `frame` high, one cycle after the pulse. They are stable for the whole frame.
- No stalls or backpressure; one register access per cycle on each port.

## Structure
- Shared package holds:
  - register index constants (`REG_STAGE_X` … `REG_FRAME_CNT`);
  - `CTRL` bit positions and `STATUS` bit positions;
  - reset-position localparams derived from H_RES/V_RES/draw size.
- One sub-module: `axis_step` (pos, vel, lo, hi, bounce → next_pos, next_vel, hit). It is instantiated twice, once for x and once for y, and is purely combinational.

## Test plan
1. Reset:
   - Stimulus: assert `rst` 2 cycles, release.
   - Required: `sprx`=288, `spry`=208, `spr_en`=1; read `CTRL` → 0x0007, `FRAME_CNT` → 0.
2. Motion:
   - Stimulus: 10 `frame` pulses with defaults.
   - Required: `sprx`=328, `spry`=208, `FRAME_CNT`=10.
3. Bounce right:
   - Stimulus: write `STAGE_X`=700, `CTRL`=0x000F, then pulse `frame`.
   - Required after that frame: `sprx`=700.
   - Next frame: `sprx`=704, `STATUS`=0.
   - Next frame: `sprx`=704, `VEL_X` reads 0xFFFC, `STATUS` reads 0x0002, and a second read returns 0x0000.
4. Wrap left:
   - Stimulus: `CTRL`=0x000B, `STAGE_X`=-124, `VEL_X`=-8, then frame, then frame.
   - Required: `sprx`=-124, then 704; `STATUS[0]`=1.
5. Collisions:
   - Write `VEL_X`=2 on the same cycle as a bouncing `frame`: `VEL_X` reads 2.
   - `STATUS` read on a hit-set cycle: returns 0, and the next read returns the bit set.
6. Reset mid-load:
   - Stimulus: write `STAGE_X`=100 and load, assert `rst` before `frame`, then pulse `frame`.
   - Required: `sprx`=292 (reset position plus one step), `CTRL[3]`=0.
